apb_slave_mem: RTL and testbench
================================

Name: apb_slave_mem

Overview:
APB3 completer (slave) that sits directly downstream of the bus driven by the bench BFM. It responds to psel/penable/pwrite/paddr/pwdata with pready/prdata/pslverr. It implements a word-addressed register memory with a fixed, parameterised number of wait states and error signalling. It is the DUT the APB BFM and monitor attach to.

Parameters:
ADDR_W, 32, paddr width
DATA_W, 32, pwdata/prdata width
DEPTH, 256, number of DATA_W-bit words (power of 2, >=2)
WAIT_STATES, 1, extra access-phase cycles before pready (0..15)

Ports:
pclk  input  1  clock; all logic on rising edge
presetn  input  1  synchronous, active-high reset (1 = reset), sampled on pclk
psel  input  1  completer select
penable  input  1  access-phase strobe
pwrite  input  1  1 = write, 0 = read
paddr  input  ADDR_W  byte address
pwdata  input  DATA_W  write data
prdata  output  DATA_W  read data, registered
pready  output  1  transfer complete, registered
pslverr  output  1  transfer error, registered, valid only with pready

Behaviour:
- Reset (presetn=1 at an edge): state=IDLE, cnt=0, pready=0, pslverr=0, prdata=0, all memory words cleared to 0. Reset overrides any transfer in progress, and nothing is committed.
- Word index = paddr[2 +: $clog2(DEPTH)]. Error condition err = (paddr[1:0]!=0) or (paddr>>2 >= DEPTH).
- FSM states IDLE, ACCESS:
  - IDLE: edge with psel=1 and penable=0 (setup phase) latches addr/dir/data and goes to ACCESS.
    - If WAIT_STATES==0: set pready=1 at this edge (do the read-data load, see below), cnt=0.
    - Else: pready=0, cnt=WAIT_STATES.
  - IDLE: psel=1 with penable=1 (no setup) is ignored; stay IDLE, outputs 0.
  - ACCESS, pready=0, psel=1, penable=1: decrement cnt. When cnt==1, set pready=1 at this edge.
  - ACCESS, psel=1, penable=1, pready=1 (completion edge): commit the write if pwrite=1 and !err. Then pready->0, pslverr->0, go to IDLE.
  - ACCESS, psel=0 at any edge (abort): go to IDLE, pready=0, pslverr=0, no write.
- Latency: access phase lasts exactly WAIT_STATES+1 cycles. Zero-wait transfer = 2 cycles (setup + access).
- Read data: prdata is loaded at the edge that raises pready, with mem[index] or 0 if err. It holds that value until the next read load. Writes never change prdata.
- pslverr is set together with pready when err=1. An erroring write leaves memory unchanged.
- Completer uses the latched addr/pwrite captured in setup. paddr/pwrite changes during the access phase are ignored.
- Back-to-back: a setup phase in the cycle right after a completion edge is accepted (state is IDLE again). No dead cycle is required.
- Write followed by read of the same word returns the new data.

Decomposition:
- Shared package apb_pkg:
  - typedef enum logic {IDLE, ACCESS} apb_state_e
  - localparam defaults for ADDR_W and DATA_W
  - function to compute the err condition
- One sub-module: apb_mem_array, a DEPTH x DATA_W storage with synchronous clear, synchronous write enable and combinational read port. The FSM, wait counter and output registers stay in apb_slave_mem.

Test Plan:
- Reset check: hold presetn=1 for 2 cycles, then release -> pready=0, pslverr=0, prdata=0. A read of addr 0x10 returns 0x0, pslverr=0.
- Write/read, WAIT_STATES=1: write 0xDEADBEEF to 0x04, then read 0x04 -> each access phase 2 cycles with pready high only in the 2nd. prdata=0xDEADBEEF, pslverr=0.
- WAIT_STATES=0 back-to-back: write 0x11 to 0x00, 0x22 to 0x3FC, 0x33 to 0x08 with consecutive setups -> each transfer completes in 2 cycles. Reads return 0x11, 0x22, 0x33.
- Errors: write 0xAAAA to 0x400 (out of range, DEPTH=256) and to 0x02 (misaligned) -> pslverr=1 with pready. A read of 0x400 gives prdata=0, pslverr=1. A read of 0x00 still returns 0x11.
- Abort: setup a write of 0x55 to 0x0C, drop psel in the 1st access cycle (WAIT_STATES=2) -> pready never rises. A subsequent read of 0x0C returns the old value 0x0.
- Reset mid-transfer: assert presetn during the access phase of a write to 0x20 -> next cycle pready=0, state IDLE. A read of 0x20 returns 0.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and helpers for the APB3 register-memory completer.
package apb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_state_e;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  // A byte address is rejected when it is not word aligned or when its word
  // index falls beyond the end of the memory.
  function automatic logic addr_err(input logic [63:0] addr, input logic [31:0] depth);
    return (addr[1:0] != 2'b00) || ((addr >> 2) >= {32'd0, depth});
  endfunction

endpackage

// File: rtl/apb_mem_array.sv
// DEPTH x DATA_W word storage: synchronous clear, synchronous write,
// combinational read.
module apb_mem_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              we,
  input  logic [IDX_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Clear every word on reset, otherwise perform the single-port write.
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/apb_slave_mem.sv
// APB3 completer backed by a word-addressed register memory, with a fixed
// number of wait states and error response on bad addresses.
module apb_slave_mem
  import apb_pkg::*;
#(
  parameter int ADDR_W      = APB_ADDR_W,
  parameter int DATA_W      = APB_DATA_W,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr
);

  localparam int IDX_W = $clog2(DEPTH);

  apb_state_e        state;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] addr_q;
  logic              write_q;
  logic [DATA_W-1:0] wdata_q;

  logic              setup;
  logic              err_in;
  logic              err_q;
  logic              wr_en;
  logic [IDX_W-1:0]  rd_idx;
  logic [DATA_W-1:0] rd_data;

  assign setup  = psel && !penable;
  assign err_in = addr_err(64'(paddr), 32'(DEPTH));
  assign err_q  = addr_err(64'(addr_q), 32'(DEPTH));

  // In IDLE the zero-wait read must see the live address; once in ACCESS
  // everything is taken from the address captured during setup.
  assign rd_idx = (state == IDLE) ? paddr[2 +: IDX_W] : addr_q[2 +: IDX_W];

  assign wr_en = !presetn && (state == ACCESS) && psel && penable && pready &&
                 write_q && !err_q;

  apb_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (pclk),
    .clr   (presetn),
    .we    (wr_en),
    .waddr (addr_q[2 +: IDX_W]),
    .wdata (wdata_q),
    .raddr (rd_idx),
    .rdata (rd_data)
  );

  // Capture the transfer attributes at the setup edge.
  always_ff @(posedge pclk) begin
    if (state == IDLE && setup) begin
      addr_q  <= paddr;
      write_q <= pwrite;
      wdata_q <= pwdata;
    end
  end

  // Transfer FSM, wait-state counter and registered response outputs.
  always_ff @(posedge pclk) begin
    if (presetn) begin
      state   <= IDLE;
      cnt     <= '0;
      pready  <= 1'b0;
      pslverr <= 1'b0;
      prdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (setup) begin
            state <= ACCESS;
            if (WAIT_STATES == 0) begin
              cnt     <= '0;
              pready  <= 1'b1;
              pslverr <= err_in;
              if (!pwrite) prdata <= err_in ? '0 : rd_data;
            end else begin
              cnt     <= 4'(WAIT_STATES);
              pready  <= 1'b0;
              pslverr <= 1'b0;
            end
          end else begin
            pready  <= 1'b0;
            pslverr <= 1'b0;
          end
        end
        ACCESS: begin
          if (!psel) begin
            state   <= IDLE;
            pready  <= 1'b0;
            pslverr <= 1'b0;
          end else if (penable) begin
            if (pready) begin
              state   <= IDLE;
              pready  <= 1'b0;
              pslverr <= 1'b0;
            end else begin
              cnt <= cnt - 4'd1;
              if (cnt == 4'd1) begin
                pready  <= 1'b1;
                pslverr <= err_q;
                if (!write_q) prdata <= err_q ? '0 : rd_data;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_slave_mem.sv
// Bench for apb_slave_mem: three instances with 0, 1 and 2 wait states share
// clock and reset; directed vector table, hand-written corner sequences and
// randomized transfers checked against an array-based memory model.
module tb_apb_slave_mem;

  logic        clk;
  logic        presetn;
  logic        psel    [3];
  logic        penable [3];
  logic        pwrite  [3];
  logic [31:0] paddr   [3];
  logic [31:0] pwdata  [3];
  logic [31:0] prdata  [3];
  logic        pready  [3];
  logic        pslverr [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    apb_slave_mem #(
      .ADDR_W      (32),
      .DATA_W      (32),
      .DEPTH       (256),
      .WAIT_STATES (g)
    ) u_dut (
      .pclk    (clk),
      .presetn (presetn),
      .psel    (psel[g]),
      .penable (penable[g]),
      .pwrite  (pwrite[g]),
      .paddr   (paddr[g]),
      .pwdata  (pwdata[g]),
      .prdata  (prdata[g]),
      .pready  (pready[g]),
      .pslverr (pslverr[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int vectors;
  int miscompares;

  // Reference model: plain word arrays per instance plus the last read value.
  logic [31:0] mem_m   [3][256];
  logic [31:0] last_rd [3];

  typedef struct {
    int          d;
    bit          wr;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    bit          err;
    bit          b2b;
  } vec_t;

  vec_t tbl[$];

  function automatic bit model_err(input logic [31:0] a);
    return (a % 4 != 0) || ((a / 4) >= 256);
  endfunction

  task automatic model_clear();
    for (int d = 0; d < 3; d++) begin
      last_rd[d] = '0;
      for (int i = 0; i < 256; i++) mem_m[d][i] = '0;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idle(input int d);
    psel[d]    = 1'b0;
    penable[d] = 1'b0;
    @(posedge clk); #1;
  endtask

  // One complete transfer; the address bus and direction are scrambled during
  // the access phase to confirm the completer works from its setup snapshot.
  task automatic xfer(input int d, input bit wr, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] exp_rd, input bit exp_err);
    int cyc;
    bit done;
    psel[d]    = 1'b1;
    penable[d] = 1'b0;
    pwrite[d]  = wr;
    paddr[d]   = a;
    pwdata[d]  = wd;
    @(posedge clk); #1;
    penable[d] = 1'b1;
    paddr[d]   = $urandom;
    pwrite[d]  = ~wr;
    pwdata[d]  = $urandom;
    cyc  = 1;
    done = 0;
    while (!done && cyc <= 20) begin
      if (pready[d] === 1'b1) done = 1;
      else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    check($sformatf("latency d%0d a=%h", d, a), 32'(cyc), 32'(d + 1));
    if (done) begin
      check($sformatf("pslverr d%0d a=%h", d, a), {31'd0, pslverr[d]}, {31'd0, exp_err});
      check($sformatf("prdata d%0d %s a=%h", d, wr ? "wr" : "rd", a), prdata[d],
            wr ? last_rd[d] : exp_rd);
      @(posedge clk); #1;
      check($sformatf("pready_drop d%0d a=%h", d, a), {31'd0, pready[d]}, 32'd0);
      if (wr && !model_err(a)) mem_m[d][a[9:2]] = wd;
      if (!wr) last_rd[d] = exp_rd;
    end
  endtask

  task automatic do_reset();
    presetn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    presetn = 1'b0;
    model_clear();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    presetn     = 1'b1;
    for (int d = 0; d < 3; d++) begin
      psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0;
      paddr[d] = '0;  pwdata[d] = '0;
    end

    //               d  wr  addr          wdata         rdata         err b2b
    tbl.push_back('{1, 0, 32'h0000_0010, 32'h0,        32'h0,        0, 0});
    tbl.push_back('{1, 1, 32'h0000_0004, 32'hDEADBEEF, 32'h0,        0, 0});
    tbl.push_back('{1, 0, 32'h0000_0004, 32'h0,        32'hDEADBEEF, 0, 0});
    tbl.push_back('{0, 1, 32'h0000_0000, 32'h11,       32'h0,        0, 1});
    tbl.push_back('{0, 1, 32'h0000_03FC, 32'h22,       32'h0,        0, 1});
    tbl.push_back('{0, 1, 32'h0000_0008, 32'h33,       32'h0,        0, 1});
    tbl.push_back('{0, 0, 32'h0000_0000, 32'h0,        32'h11,       0, 1});
    tbl.push_back('{0, 0, 32'h0000_03FC, 32'h0,        32'h22,       0, 1});
    tbl.push_back('{0, 0, 32'h0000_0008, 32'h0,        32'h33,       0, 0});
    tbl.push_back('{0, 1, 32'h0000_0400, 32'hAAAA,     32'h0,        1, 0});
    tbl.push_back('{0, 1, 32'h0000_0002, 32'hAAAA,     32'h0,        1, 0});
    tbl.push_back('{0, 0, 32'h0000_0400, 32'h0,        32'h0,        1, 0});
    tbl.push_back('{0, 0, 32'h0000_0000, 32'h0,        32'h11,       0, 0});
    tbl.push_back('{0, 0, 32'h0000_0002, 32'h0,        32'h0,        1, 0});
    tbl.push_back('{2, 1, 32'h0000_0010, 32'h1234_5678, 32'h0,       0, 0});
    tbl.push_back('{2, 0, 32'h0000_0010, 32'h0,        32'h1234_5678, 0, 0});

    do_reset();
    for (int d = 0; d < 3; d++) begin
      check($sformatf("reset pready d%0d", d),  {31'd0, pready[d]},  32'd0);
      check($sformatf("reset pslverr d%0d", d), {31'd0, pslverr[d]}, 32'd0);
      check($sformatf("reset prdata d%0d", d),  prdata[d],           32'd0);
    end

    foreach (tbl[i]) begin
      xfer(tbl[i].d, tbl[i].wr, tbl[i].a, tbl[i].wd, tbl[i].rd, tbl[i].err);
      if (!tbl[i].b2b) idle(tbl[i].d);
    end

    // Abort: psel dropped during the first access cycle, nothing committed.
    psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1;
    paddr[2] = 32'h0C; pwdata[2] = 32'h55;
    @(posedge clk); #1;
    check("abort first access pready", {31'd0, pready[2]}, 32'd0);
    psel[2] = 1'b0; penable[2] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check($sformatf("abort pready cycle %0d", k), {31'd0, pready[2]}, 32'd0);
    end
    xfer(2, 0, 32'h0C, 32'h0, 32'h0, 0);
    idle(2);

    // Reset asserted in the access phase of a write.
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
    paddr[1] = 32'h20; pwdata[1] = 32'h99;
    @(posedge clk); #1;
    penable[1] = 1'b1;
    presetn    = 1'b1;
    @(posedge clk); #1;
    check("midreset pready", {31'd0, pready[1]}, 32'd0);
    check("midreset prdata", prdata[1], 32'd0);
    presetn = 1'b0;
    psel[1] = 1'b0; penable[1] = 1'b0;
    model_clear();
    @(posedge clk); #1;
    check("midreset pready idle", {31'd0, pready[1]}, 32'd0);
    xfer(1, 0, 32'h20, 32'h0, 32'h0, 0);
    idle(1);
    xfer(1, 0, 32'h04, 32'h0, 32'h0, 0);
    idle(1);

    // Randomized traffic against the model.
    for (int n = 0; n < 120; n++) begin
      int d;
      bit wr;
      bit err;
      int r;
      logic [31:0] a;
      logic [31:0] wd;
      logic [31:0] exp_rd;
      d  = $urandom_range(0, 2);
      wr = 1'($urandom_range(0, 1));
      r  = $urandom_range(0, 9);
      if (r < 6)       a = 32'($urandom_range(0, 7)) * 4;
      else if (r == 6) a = 32'($urandom_range(0, 255)) * 4;
      else if (r == 7) a = 32'h400 + 32'($urandom_range(0, 1000)) * 4;
      else if (r == 8) a = 32'($urandom_range(0, 7)) * 4 + 32'($urandom_range(1, 3));
      else             a = $urandom;
      wd     = $urandom;
      err    = model_err(a);
      exp_rd = err ? 32'h0 : mem_m[d][a[9:2]];
      xfer(d, wr, a, wd, exp_rd, err);
      if ($urandom_range(0, 1) == 0) idle(d);
      else begin
        psel[d]    = 1'b0;
        penable[d] = 1'b0;
      end
    end

    for (int d = 0; d < 3; d++) idle(d);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
